spi_protocol_monitor: RTL and testbench

SPI_PROTOCOL_MONITOR -- requirements
Module: spi_protocol_monitor

---
 rtl/spi_pkg.sv | 34 +++
 rtl/sat_counter.sv | 34 +++
 rtl/spi_protocol_monitor.sv | 235 +++++++++++++++++++++++
 tb/tb_spi_protocol_monitor.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI protocol monitor:
//   cmd_e    - two-bit command field carried at the head of every frame
//   state_e  - monitor FSM states
//   ERR_*    - bit positions inside the sticky err_flags vector
// ---------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SHIFT      = 3'd1,
        ST_WAIT_VALID = 3'd2,
        ST_WAIT_TX    = 3'd3,
        ST_CHECK_MISO = 3'd4
    } state_e;

    localparam int ERR_EARLY_VALID    = 0;
    localparam int ERR_RXDATA_MISMATCH = 1;
    localparam int ERR_MISSING_VALID  = 2;
    localparam int ERR_VALID_LONG     = 3;
    localparam int ERR_READ_ORDER     = 4;
    localparam int ERR_TX_TIMEOUT     = 5;
    localparam int ERR_MISO_MISMATCH  = 6;
    localparam int ERR_ABORT          = 7;

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear.
//   clk   - clock (rising edge)
//   rst   - synchronous active-high reset, highest priority
//   clr   - synchronous clear; an inc in the same cycle leaves the count at 1
//   inc   - count one event this cycle
//   count - current value, sticks at all-ones
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= inc ? W'(1) : '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/spi_protocol_monitor.sv
// ---------------------------------------------------------------------------
// spi_protocol_monitor
// Passive checker for an SPI slave. It follows each frame on SCK, captures
// the command/payload from MOSI, and checks the slave's rx_valid/rx_data
// report, the read command ordering, the tx_valid turnaround after a
// read-data frame and the MISO bits returned for it.
//
// Ports
//   SCK                    - sole clock, rising edge
//   rst                    - synchronous active-high reset
//   SS_n, MOSI, MISO       - observed SPI lines
//   rx_valid, rx_data      - slave's "frame received" strobe and word
//   tx_valid, tx_data      - slave's "reply loaded" strobe and byte
//   clr                    - synchronous clear of flags and counters
//   err_flags              - sticky per-class error bits (see spi_pkg ERR_*)
//   err_pulse              - one cycle high after any cycle with a new error
//   frame_cnt, err_cnt     - saturating frame / error-cycle counters
//   dbg_state_o            - current FSM state
//
// Valid/ready: there is no handshake; rx_valid and tx_valid are single-cycle
// strobes sampled on SCK and the monitor never back-pressures.
//
// Frame timing: cycle 0 is the edge where SS_n is first sampled low, MOSI
// is captured on cycles 1..N (N = DATA_W+2), rx_valid is expected on cycle
// N+1 only. For read-data frames tx_valid is accepted 1..TX_TIMEOUT cycles
// after cycle N+1, and MISO is compared on the DATA_W cycles that follow.
// ---------------------------------------------------------------------------
module spi_protocol_monitor
    import spi_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int TX_TIMEOUT = 4,
    parameter int CNT_W      = 16
) (
    input  logic                SCK,
    input  logic                rst,
    input  logic                SS_n,
    input  logic                MOSI,
    input  logic                MISO,
    input  logic                tx_valid,
    input  logic                rx_valid,
    input  logic [DATA_W-1:0]   tx_data,
    input  logic [DATA_W+1:0]   rx_data,
    input  logic                clr,
    output logic [7:0]          err_flags,
    output logic                err_pulse,
    output logic [CNT_W-1:0]    frame_cnt,
    output logic [CNT_W-1:0]    err_cnt,
    output state_e              dbg_state_o
);

    localparam int N     = DATA_W + 2;
    localparam int CYC_W = $clog2(N + TX_TIMEOUT + DATA_W + 4);

    localparam logic [CYC_W-1:0] CYC_LAST_MOSI = CYC_W'(N);
    localparam logic [CYC_W-1:0] CYC_RX        = CYC_W'(N + 1);
    localparam logic [CYC_W-1:0] CYC_DEADLINE  = CYC_W'(N + 1 + TX_TIMEOUT);
    localparam logic [CYC_W-1:0] CYC_LAST_MISO = CYC_W'(DATA_W - 1);

    state_e              state_q,     state_d;
    logic [CYC_W-1:0]    cyc_q,       cyc_d;
    logic [N-1:0]        shift_q,     shift_d;
    logic [DATA_W-1:0]   txcap_q,     txcap_d;
    logic                addr_seen_q, addr_seen_d;
    logic                ss_q;
    logic [7:0]          err_flags_q;
    logic                err_pulse_q;

    logic [7:0]          err_vec;
    logic                frame_done;
    logic                start;
    cmd_e                cmd;

    // A frame starts only on a falling SS_n; a line left low after a frame
    // has finished does not start another one.
    assign start = ss_q & ~SS_n;
    assign cmd   = cmd_e'(shift_q[N-1 -: 2]);

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        shift_d     = shift_q;
        txcap_d     = txcap_q;
        addr_seen_d = addr_seen_q;
        err_vec     = '0;
        frame_done  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid && (SS_n || start)) begin
                    err_vec[ERR_EARLY_VALID] = 1'b1;
                end
                if (start) begin
                    state_d = ST_SHIFT;
                    cyc_d   = CYC_W'(1);
                    shift_d = '0;
                end
            end

            ST_SHIFT: begin
                shift_d = {shift_q[N-2:0], MOSI};
                cyc_d   = cyc_q + 1'b1;
                if (rx_valid) begin
                    err_vec[ERR_EARLY_VALID] = 1'b1;
                end
                if (cyc_q == CYC_LAST_MOSI) begin
                    state_d = ST_WAIT_VALID;
                end
            end

            ST_WAIT_VALID: begin
                cyc_d = cyc_q + 1'b1;
                if (cyc_q == CYC_RX) begin
                    if (!rx_valid) begin
                        err_vec[ERR_MISSING_VALID] = 1'b1;
                    end else if (rx_data != shift_q) begin
                        err_vec[ERR_RXDATA_MISMATCH] = 1'b1;
                    end
                    // Ordering is judged on the captured command, whether
                    // or not the slave reported the frame.
                    case (cmd)
                        CMD_RD_ADDR: addr_seen_d = 1'b1;
                        CMD_RD_DATA: begin
                            if (!addr_seen_q) begin
                                err_vec[ERR_READ_ORDER] = 1'b1;
                            end
                            addr_seen_d = 1'b0;
                        end
                        default: ;
                    endcase
                end else begin
                    if (rx_valid) begin
                        err_vec[ERR_VALID_LONG] = 1'b1;
                    end
                    if (cmd == CMD_RD_DATA) begin
                        // This cycle is already the first tx_valid slot.
                        if (tx_valid) begin
                            txcap_d = tx_data;
                            cyc_d   = '0;
                            state_d = ST_CHECK_MISO;
                        end else if (cyc_q == CYC_DEADLINE) begin
                            err_vec[ERR_TX_TIMEOUT] = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_WAIT_TX;
                        end
                    end else begin
                        frame_done = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
            end

            ST_WAIT_TX: begin
                cyc_d = cyc_q + 1'b1;
                if (tx_valid) begin
                    txcap_d = tx_data;
                    cyc_d   = '0;
                    state_d = ST_CHECK_MISO;
                end else if (cyc_q == CYC_DEADLINE) begin
                    // A timed-out read never reaches its MISO check, so it
                    // is not counted as a completed frame.
                    err_vec[ERR_TX_TIMEOUT] = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            ST_CHECK_MISO: begin
                cyc_d   = cyc_q + 1'b1;
                txcap_d = txcap_q << 1;
                if (MISO != txcap_q[DATA_W-1]) begin
                    err_vec[ERR_MISO_MISMATCH] = 1'b1;
                end
                if (cyc_q == CYC_LAST_MISO) begin
                    frame_done = 1'b1;
                    state_d    = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Deselect mid-frame overrides every other check of that cycle.
        if ((state_q != ST_IDLE) && SS_n) begin
            err_vec            = '0;
            err_vec[ERR_ABORT] = 1'b1;
            frame_done         = 1'b0;
            addr_seen_d        = addr_seen_q;
            state_d            = ST_IDLE;
        end
    end

    always_ff @(posedge SCK) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cyc_q       <= '0;
            shift_q     <= '0;
            txcap_q     <= '0;
            addr_seen_q <= 1'b0;
            ss_q        <= 1'b1;
            err_flags_q <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            shift_q     <= shift_d;
            txcap_q     <= txcap_d;
            addr_seen_q <= addr_seen_d;
            ss_q        <= SS_n;
            err_flags_q <= (clr ? 8'h00 : err_flags_q) | err_vec;
            err_pulse_q <= |err_vec;
        end
    end

    sat_counter #(.W(CNT_W)) u_frame_cnt (
        .clk   (SCK),
        .rst   (rst),
        .clr   (clr),
        .inc   (frame_done),
        .count (frame_cnt)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (SCK),
        .rst   (rst),
        .clr   (clr),
        .inc   (|err_vec),
        .count (err_cnt)
    );

    assign err_flags   = err_flags_q;
    assign err_pulse   = err_pulse_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_protocol_monitor.sv
// ---------------------------------------------------------------------------
// tb_spi_protocol_monitor
// Frame-level bench: directed frame table with hand-derived expectations,
// a few hand-written multi-cycle sequences, then random frames checked
// against an event-list model of the monitor's rules.
// ---------------------------------------------------------------------------
module tb_spi_protocol_monitor;
    import spi_pkg::*;

    localparam int DW   = 8;
    localparam int N    = DW + 2;
    localparam int TXTO = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic            SCK = 1'b0;
    logic            rst, SS_n, MOSI, MISO, tx_valid, rx_valid, clr;
    logic [DW-1:0]   tx_data;
    logic [DW+1:0]   rx_data;
    logic [7:0]      err_flags;
    logic            err_pulse;
    logic [CW-1:0]   frame_cnt, err_cnt;
    state_e          dbg_state;

    spi_protocol_monitor #(.DATA_W(DW), .TX_TIMEOUT(TXTO), .CNT_W(CW)) dut (
        .SCK         (SCK),
        .rst         (rst),
        .SS_n        (SS_n),
        .MOSI        (MOSI),
        .MISO        (MISO),
        .tx_valid    (tx_valid),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .rx_data     (rx_data),
        .clr         (clr),
        .err_flags   (err_flags),
        .err_pulse   (err_pulse),
        .frame_cnt   (frame_cnt),
        .err_cnt     (err_cnt),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 SCK = ~SCK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- frame description ----------------
    // rx_mode: 0 correct report, 1 missing, 2 wrong data, 3 held two cycles
    typedef struct {
        logic        do_clr;
        logic [1:0]  cmd;
        logic [7:0]  payload;
        int          rx_mode;
        int          early;
        int          abort_c;
        int          tx_delay;
        logic [7:0]  tx_byte;
        logic [7:0]  miso_byte;
        logic [7:0]  exp_flags;
        int          exp_err;
        int          exp_frame;
        int          exp_pulses;
    } vec_t;

    function automatic vec_t mk(logic c, logic [1:0] cmd, logic [7:0] pl, int rxm,
                                int early, int ab, int d, logic [7:0] tx, logic [7:0] mi,
                                logic [7:0] ef, int ee, int efr, int ep);
        vec_t v;
        v.do_clr = c; v.cmd = cmd; v.payload = pl; v.rx_mode = rxm;
        v.early = early; v.abort_c = ab; v.tx_delay = d;
        v.tx_byte = tx; v.miso_byte = mi;
        v.exp_flags = ef; v.exp_err = ee; v.exp_frame = efr; v.exp_pulses = ep;
        return v;
    endfunction

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int pulse_seen;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge SCK);
        #1;
        if (err_pulse) pulse_seen++;
    endtask

    task automatic idle();
        SS_n = 1'b1; MOSI = 1'b0; MISO = 1'b0;
        rx_valid = 1'b0; tx_valid = 1'b0; clr = 1'b0;
        step();
    endtask

    task automatic clear();
        idle();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic run_frame(input vec_t f);
        int len;
        logic [N-1:0] word;
        word = {f.cmd, f.payload};
        if (f.abort_c >= 0)          len = f.abort_c + 1;
        else if (f.cmd != 2'b11)     len = N + 3;
        else if (f.tx_delay > TXTO)  len = N + 2 + TXTO;
        else                         len = N + 2 + f.tx_delay + DW;
        for (int c = 0; c < len; c++) begin
            SS_n     = (c == f.abort_c);
            MOSI     = (c >= 1 && c <= N) ? word[N-c] : 1'b0;
            rx_valid = (c == f.early) || (c == N + 1 && f.rx_mode != 1) ||
                       (c == N + 2 && f.rx_mode == 3);
            rx_data  = (c == N + 1 && f.rx_mode == 2) ? (word ^ 10'h001) : word;
            tx_valid = (f.cmd == 2'b11) && (c == N + 1 + f.tx_delay);
            tx_data  = f.tx_byte;
            MISO     = (f.cmd == 2'b11 && c >= N + 2 + f.tx_delay && c <= N + 1 + f.tx_delay + DW)
                       ? f.miso_byte[DW-1-(c-(N+2+f.tx_delay))] : 1'b0;
            step();
        end
        idle();
        idle();
    endtask

    // ---------------- reference model ----------------
    // Lists every error the frame should raise, keyed by frame cycle;
    // one err_pulse / err_cnt step per cycle that has any error.
    logic [7:0] m_flags;
    int         m_err, m_frame;
    logic       m_addr_seen;

    function automatic int sat(int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic model_frame(input vec_t f, output int nerr);
        logic [7:0] ev [0:63];
        for (int k = 0; k < 64; k++) ev[k] = 8'h00;
        if (f.early >= 0) ev[f.early] |= 8'h01;
        if (f.abort_c >= 0) begin
            ev[f.abort_c] |= 8'h80;
        end else begin
            if (f.rx_mode == 1) ev[N+1] |= 8'h04;
            if (f.rx_mode == 2) ev[N+1] |= 8'h02;
            if (f.cmd == 2'b11 && !m_addr_seen) ev[N+1] |= 8'h10;
            if (f.rx_mode == 3) ev[N+2] |= 8'h08;
            if (f.cmd == 2'b10) m_addr_seen = 1'b1;
            if (f.cmd == 2'b11) m_addr_seen = 1'b0;
            if (f.cmd != 2'b11) begin
                m_frame = sat(m_frame + 1);
            end else if (f.tx_delay > TXTO) begin
                ev[N+1+TXTO] |= 8'h20;
            end else begin
                for (int j = 0; j < DW; j++)
                    if (f.miso_byte[DW-1-j] != f.tx_byte[DW-1-j]) ev[N+2+f.tx_delay+j] |= 8'h40;
                m_frame = sat(m_frame + 1);
            end
        end
        nerr = 0;
        for (int k = 0; k < 64; k++) begin
            if (ev[k] != 8'h00) begin
                nerr++;
                m_flags |= ev[k];
            end
        end
        m_err = sat(m_err + nerr);
    endtask

    // ---------------- stimulus ----------------
    vec_t tbl [0:14];

    initial begin
        vec_t f;
        int   nerr;

        tbl[0]  = mk(1, 2'b00, 8'hA5, 0, -1, -1, 1, 8'h00, 8'h00, 8'h00, 0, 1, 0);
        tbl[1]  = mk(1, 2'b11, 8'h00, 0, -1, -1, 1, 8'h5A, 8'h5A, 8'h10, 1, 1, 1);
        tbl[2]  = mk(1, 2'b10, 8'h11, 0, -1, -1, 1, 8'h00, 8'h00, 8'h00, 0, 1, 0);
        tbl[3]  = mk(0, 2'b11, 8'h22, 0, -1, -1, 2, 8'h3C, 8'h3D, 8'h40, 1, 2, 1);
        tbl[4]  = mk(1, 2'b01, 8'h33, 0,  5, -1, 1, 8'h00, 8'h00, 8'h01, 1, 1, 1);
        tbl[5]  = mk(1, 2'b00, 8'h44, 0, -1,  6, 1, 8'h00, 8'h00, 8'h80, 1, 0, 1);
        tbl[6]  = mk(1, 2'b10, 8'h55, 1, -1, -1, 1, 8'h00, 8'h00, 8'h04, 1, 1, 1);
        tbl[7]  = mk(0, 2'b11, 8'h66, 2, -1, -1, 1, 8'h81, 8'h81, 8'h06, 2, 2, 1);
        tbl[8]  = mk(1, 2'b01, 8'h77, 3, -1, -1, 1, 8'h00, 8'h00, 8'h08, 1, 1, 1);
        tbl[9]  = mk(1, 2'b11, 8'h00, 0, -1, -1, 5, 8'h12, 8'h12, 8'h30, 2, 0, 2);
        tbl[10] = mk(1, 2'b11, 8'h99, 0, -1, -1, 4, 8'hC3, 8'hC3, 8'h10, 1, 1, 1);
        tbl[11] = mk(1, 2'b11, 8'hAA, 0,  0, -1, 1, 8'h0F, 8'h0F, 8'h11, 2, 1, 2);
        tbl[12] = mk(1, 2'b10, 8'hBB, 3, -1, -1, 1, 8'h00, 8'h00, 8'h08, 1, 1, 1);
        tbl[13] = mk(0, 2'b11, 8'hCC, 0, -1, -1, 1, 8'h00, 8'hFF, 8'h48, 9, 2, 8);
        tbl[14] = mk(0, 2'b00, 8'hDD, 1,  3, -1, 1, 8'h00, 8'h00, 8'h4D, 11, 3, 2);

        rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; MISO = 1'b0; clr = 1'b0;
        rx_valid = 1'b0; tx_valid = 1'b0; tx_data = '0; rx_data = '0;
        pulse_seen = 0;
        repeat (3) step();
        chk("reset flags", int'(err_flags), 0);
        chk("reset pulse", int'(err_pulse), 0);
        chk("reset frame_cnt", int'(frame_cnt), 0);
        chk("reset err_cnt", int'(err_cnt), 0);
        chk("reset state", int'(dbg_state), int'(ST_IDLE));
        rst = 1'b0;
        idle();

        // ---- directed frame table ----
        for (int i = 0; i < 15; i++) begin
            if (tbl[i].do_clr) clear();
            pulse_seen = 0;
            run_frame(tbl[i]);
            chk($sformatf("tbl%0d flags", i), int'(err_flags), int'(tbl[i].exp_flags));
            chk($sformatf("tbl%0d err_cnt", i), int'(err_cnt), tbl[i].exp_err);
            chk($sformatf("tbl%0d frame_cnt", i), int'(frame_cnt), tbl[i].exp_frame);
            chk($sformatf("tbl%0d pulses", i), pulse_seen, tbl[i].exp_pulses);
        end

        // ---- clr wipes everything ----
        clear();
        chk("clr flags", int'(err_flags), 0);
        chk("clr pulse", int'(err_pulse), 0);
        chk("clr frame_cnt", int'(frame_cnt), 0);
        chk("clr err_cnt", int'(err_cnt), 0);

        // ---- deselect on cycle 6 ----
        idle();
        for (int c = 0; c < 6; c++) begin
            SS_n = 1'b0; MOSI = c[0];
            step();
        end
        chk("abort mid state", int'(dbg_state), int'(ST_SHIFT));
        SS_n = 1'b1;
        step();
        chk("abort state", int'(dbg_state), int'(ST_IDLE));
        chk("abort pulse", int'(err_pulse), 1);
        chk("abort flags", int'(err_flags), 8'h80);
        chk("abort frame_cnt", int'(frame_cnt), 0);
        idle();
        chk("abort pulse drop", int'(err_pulse), 0);

        // ---- error in the same cycle as clr ----
        run_frame(mk(0, 2'b01, 8'h3E, 0, -1, -1, 1, 8'h00, 8'h00, 8'h00, 0, 0, 0));
        chk("pre-clr frame_cnt", int'(frame_cnt), 1);
        SS_n = 1'b1; clr = 1'b1; rx_valid = 1'b1;
        step();
        clr = 1'b0; rx_valid = 1'b0;
        chk("clr+err flags", int'(err_flags), 8'h01);
        chk("clr+err err_cnt", int'(err_cnt), 1);
        chk("clr+err frame_cnt", int'(frame_cnt), 0);

        // ---- reset in the middle of a frame ----
        idle();
        for (int c = 0; c < 5; c++) begin
            SS_n = 1'b0; MOSI = 1'b1;
            step();
        end
        rst = 1'b1; clr = 1'b1; rx_valid = 1'b1;
        step();
        chk("rst mid flags", int'(err_flags), 0);
        chk("rst mid pulse", int'(err_pulse), 0);
        chk("rst mid err_cnt", int'(err_cnt), 0);
        chk("rst mid state", int'(dbg_state), int'(ST_IDLE));
        rst = 1'b0; clr = 1'b0; rx_valid = 1'b0;
        idle();
        run_frame(mk(0, 2'b00, 8'h5C, 0, -1, -1, 1, 8'h00, 8'h00, 8'h00, 0, 0, 0));
        chk("post-rst frame_cnt", int'(frame_cnt), 1);
        chk("post-rst err_cnt", int'(err_cnt), 0);

        // ---- random frames against the model ----
        rst = 1'b1;
        idle();
        rst = 1'b0;
        idle();
        m_flags = 8'h00; m_err = 0; m_frame = 0; m_addr_seen = 1'b0;
        for (int i = 0; i < 120; i++) begin
            int r;
            f = mk(0, 2'($urandom_range(0, 3)), 8'($urandom), 0, -1, -1,
                   $urandom_range(1, 6), 8'($urandom), 8'h00, 8'h00, 0, 0, 0);
            r = $urandom_range(0, 9);
            f.rx_mode   = (r == 6) ? 1 : (r == 7) ? 2 : (r == 8) ? 3 : 0;
            f.early     = ($urandom_range(0, 7) == 0) ? $urandom_range(0, N) : -1;
            f.abort_c   = ($urandom_range(0, 9) == 0) ? $urandom_range(1, N) : -1;
            if (f.abort_c >= 0) f.early = -1;
            f.miso_byte = ($urandom_range(0, 3) == 0)
                          ? (f.tx_byte ^ (8'h01 << $urandom_range(0, 7))) : f.tx_byte;
            if ($urandom_range(0, 24) == 0) begin
                clear();
                m_flags = 8'h00; m_err = 0; m_frame = 0;
            end
            model_frame(f, nerr);
            pulse_seen = 0;
            run_frame(f);
            chk($sformatf("rnd%0d flags", i), int'(err_flags), int'(m_flags));
            chk($sformatf("rnd%0d err_cnt", i), int'(err_cnt), m_err);
            chk($sformatf("rnd%0d frame_cnt", i), int'(frame_cnt), m_frame);
            chk($sformatf("rnd%0d pulses", i), pulse_seen, nerr);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
